// File: rtl/df_deadlock_watchdog_pkg.sv
// rtl/df_deadlock_watchdog_pkg.sv - shared types and constants for the dataflow deadlock watchdog
//
// Package df_wd_pkg: FSM state enum, report kind encodings, default
// persistence threshold and small helper functions.
package df_wd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WATCH,
        ST_CONFIRM,
        ST_REPORT,
        ST_DONE
    } wd_state_e;

    localparam logic [1:0] KIND_CHAN = 2'b01;
    localparam logic [1:0] KIND_AXIS = 2'b10;
    localparam logic [1:0] KIND_BOTH = 2'b11;

    localparam int DEFAULT_THRESH = 16;

    // Index width that stays legal for a single-process build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] kind_of(input logic chan, input logic axis);
        if (chan && axis) begin
            return KIND_BOTH;
        end else if (axis) begin
            return KIND_AXIS;
        end
        return KIND_CHAN;
    endfunction

endpackage

// File: rtl/df_deadlock_watchdog_if.sv
// rtl/df_deadlock_watchdog_if.sv - report stream interface of the deadlock watchdog
//
// Signals: rpt_valid/rpt_ready handshake, rpt_idx (process index),
// rpt_kind (bit0 channel block, bit1 axis block), rpt_last (final entry),
// rpt_time (confirmation cycle stamp).
// Modports: master = watchdog (producer), slave = logger (consumer).
interface df_deadlock_watchdog_if #(
    parameter int IDX_W = 4
) ();
    logic             rpt_valid;
    logic             rpt_ready;
    logic [IDX_W-1:0] rpt_idx;
    logic [1:0]       rpt_kind;
    logic             rpt_last;
    logic [31:0]      rpt_time;

    modport master (
        output rpt_valid,
        output rpt_idx,
        output rpt_kind,
        output rpt_last,
        output rpt_time,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_idx,
        input  rpt_kind,
        input  rpt_last,
        input  rpt_time,
        output rpt_ready
    );
endinterface

// File: rtl/df_deadlock_watchdog_persist_cnt.sv
// rtl/df_deadlock_watchdog_persist_cnt.sv - saturating persistence counter
//
// Module df_wd_persist_cnt.
// Ports: clock, reset (sync, active-high), clr_i (zero the count),
// inc_i (add one, saturating at all-ones), cnt_o (current count),
// hit_o (count equals THRESH-1, i.e. the next stop cycle confirms).
module df_wd_persist_cnt #(
    parameter int CNT_W  = 16,
    parameter int THRESH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == HIT_VAL);

endmodule

// File: rtl/df_deadlock_watchdog.sv
// rtl/df_deadlock_watchdog.sv - dataflow deadlock watchdog with serial stall report
//
// Ports: clock, reset (sync, active-high), enable (armed), clear (pulse back
// to WATCH), inst_idle_sigs / inst_block_sigs / axis_block_sigs (per-process
// status), deadlock (latched flag), busy (CONFIRM or REPORT), stall_cnt
// (persistence count), rpt (report stream, master side).
// Optional macro DF_WD_TIMESTAMP_EN: free-running 32-bit cycle counter whose
// value at confirmation is returned on rpt_time; otherwise rpt_time is 0.
module df_deadlock_watchdog
    import df_wd_pkg::*;
#(
    parameter int NUM_PROC = 14,
    parameter int THRESH   = DEFAULT_THRESH,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_PROC-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    input  logic [NUM_PROC-1:0] axis_block_sigs,
    output logic                deadlock,
    output logic                busy,
    output logic [CNT_W-1:0]    stall_cnt,
    df_deadlock_watchdog_if.master rpt
);
    localparam int IDX_W = idx_width(NUM_PROC);

    wd_state_e          state_q;
    logic               deadlock_q;
    logic               busy_q;
    logic               rpt_valid_q;
    logic [IDX_W-1:0]   rpt_idx_q;
    logic [1:0]         rpt_kind_q;
    logic               rpt_last_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_PROC-1:0] chan_snap_q;
    logic [NUM_PROC-1:0] axis_snap_q;

    logic               stop;
    logic               hit;
    logic               clr_now;
    logic               confirm;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               more_above;
    logic [NUM_PROC-1:0] stalled;

    // Whole region stuck, and at least one process waits on an AXI stream
    // (pure channel stalls can be legitimate back-pressure).
    assign stop    = (&(inst_idle_sigs | inst_block_sigs | axis_block_sigs)) && (|axis_block_sigs);
    assign stalled = chan_snap_q | axis_snap_q;

    // clear is ignored in IDLE and beats everything else elsewhere.
    assign clr_now = clear && (state_q != ST_IDLE);
    assign confirm = !clr_now && (state_q == ST_CONFIRM) && enable && stop && hit;
    assign cnt_clr = clr_now || ((state_q == ST_CONFIRM) && !(enable && stop));
    assign cnt_inc = !clr_now && enable && stop &&
                     ((state_q == ST_WATCH) || (state_q == ST_CONFIRM));

    // Any stalled process above the scan pointer decides rpt_last.
    always_comb begin
        more_above = 1'b0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if ((i > int'(ptr_q)) && stalled[i]) begin
                more_above = 1'b1;
            end
        end
    end

    df_wd_persist_cnt #(
        .CNT_W  (CNT_W),
        .THRESH (THRESH)
    ) u_persist_cnt (
        .clock (clock),
        .reset (reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (stall_cnt),
        .hit_o (hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            deadlock_q  <= 1'b0;
            busy_q      <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_idx_q   <= '0;
            rpt_kind_q  <= '0;
            rpt_last_q  <= 1'b0;
            ptr_q       <= '0;
            chan_snap_q <= '0;
            axis_snap_q <= '0;
        end else if (clr_now) begin
            state_q     <= ST_WATCH;
            deadlock_q  <= 1'b0;
            busy_q      <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_idx_q   <= '0;
            rpt_kind_q  <= '0;
            rpt_last_q  <= 1'b0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_WATCH;
                    end
                end
                ST_WATCH: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (stop) begin
                        state_q <= ST_CONFIRM;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (!enable || !stop) begin
                        state_q <= enable ? ST_WATCH : ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (hit) begin
                        state_q     <= ST_REPORT;
                        deadlock_q  <= 1'b1;
                        chan_snap_q <= inst_block_sigs;
                        axis_snap_q <= axis_block_sigs;
                        ptr_q       <= '0;
                    end
                end
                ST_REPORT: begin
                    if (rpt_valid_q) begin
                        if (rpt.rpt_ready) begin
                            rpt_valid_q <= 1'b0;
                            if (rpt_last_q) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                            end else begin
                                ptr_q <= ptr_q + IDX_W'(1);
                            end
                        end
                    end else if (stalled[ptr_q]) begin
                        // Entry is loaded from the snapshot and held until accepted.
                        rpt_valid_q <= 1'b1;
                        rpt_idx_q   <= ptr_q;
                        rpt_kind_q  <= kind_of(chan_snap_q[ptr_q], axis_snap_q[ptr_q]);
                        rpt_last_q  <= !more_above;
                    end else begin
                        ptr_q <= ptr_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DF_WD_TIMESTAMP_EN
    logic [31:0] cyc_q;
    logic [31:0] rpt_time_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q      <= '0;
            rpt_time_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (clr_now) begin
                rpt_time_q <= '0;
            end else if (confirm) begin
                rpt_time_q <= cyc_q;
            end
        end
    end

    assign rpt.rpt_time = rpt_time_q;
`else
    logic unused_confirm;
    assign unused_confirm = confirm;
    assign rpt.rpt_time   = '0;
`endif

    assign deadlock      = deadlock_q;
    assign busy          = busy_q;
    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_idx   = rpt_idx_q;
    assign rpt.rpt_kind  = rpt_kind_q;
    assign rpt.rpt_last  = rpt_last_q;

endmodule

// File: tb/tb_df_deadlock_watchdog.sv
// tb/tb_df_deadlock_watchdog.sv - self-checking bench for df_deadlock_watchdog
module tb_df_deadlock_watchdog;
    localparam int NP = 14;
    localparam int TH = 4;
    localparam int CW = 16;
    localparam int IW = $clog2(NP);

    typedef struct {
        int idx;
        int kind;
        bit last;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          clear;
    logic [NP-1:0] idle_v;
    logic [NP-1:0] chan_v;
    logic [NP-1:0] axis_v;
    logic          deadlock;
    logic          busy;
    logic [CW-1:0] stall_cnt;

    df_deadlock_watchdog_if #(.IDX_W(IW)) rpt_if ();

    df_deadlock_watchdog #(
        .NUM_PROC (NP),
        .THRESH   (TH),
        .CNT_W    (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .clear           (clear),
        .inst_idle_sigs  (idle_v),
        .inst_block_sigs (chan_v),
        .axis_block_sigs (axis_v),
        .deadlock        (deadlock),
        .busy            (busy),
        .stall_cnt       (stall_cnt),
        .rpt             (rpt_if)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          m_armed = 0;
    bit          m_dead = 0;
    int          m_run = 0;
    int          m_dead_age = 0;
    int          m_rep_age = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_time = 0;
    ent_t        m_q[$];
    ent_t        hs_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_stop(input logic [NP-1:0] i, input logic [NP-1:0] c, input logic [NP-1:0] a);
        bit all_st = 1;
        bit any_ax = 0;
        for (int k = 0; k < NP; k++) begin
            if (!(i[k] || c[k] || a[k])) all_st = 0;
            if (a[k]) any_ax = 1;
        end
        return all_st && any_ax;
    endfunction

    // Expected report: every process with a block bit, ascending, last flag on the final one.
    task automatic build_report(input logic [NP-1:0] c, input logic [NP-1:0] a);
        int   total = 0;
        int   seen = 0;
        ent_t e;
        m_q.delete();
        for (int k = 0; k < NP; k++) if (c[k] || a[k]) total++;
        for (int k = 0; k < NP; k++) begin
            if (c[k] || a[k]) begin
                seen++;
                e.idx  = k;
                e.kind = (c[k] ? 1 : 0) + (a[k] ? 2 : 0);
                e.last = (seen == total);
                m_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        logic          p_rst, p_en, p_clr, p_rdy, p_val, p_last, eff_clr;
        logic [NP-1:0] p_i, p_c, p_a;
        logic [IW-1:0] p_idx;
        logic [1:0]    p_kind;
        ent_t          e;
        ent_t          o;
        p_rst  = reset;
        p_en   = enable;
        p_clr  = clear;
        p_rdy  = rpt_if.rpt_ready;
        p_val  = rpt_if.rpt_valid;
        p_idx  = rpt_if.rpt_idx;
        p_kind = rpt_if.rpt_kind;
        p_last = rpt_if.rpt_last;
        p_i    = idle_v;
        p_c    = chan_v;
        p_a    = axis_v;
        eff_clr = !p_rst && p_clr && m_armed;
        @(posedge clock);
        #1;
        if (p_rst) begin
            m_armed = 0; m_dead = 0; m_run = 0; m_time = 0;
            m_q.delete();
        end else if (eff_clr) begin
            m_dead = 0; m_run = 0; m_time = 0;
            m_q.delete();
        end else if (!m_armed) begin
            m_armed = p_en;
        end else if (m_dead) begin
            if (p_val && p_rdy) begin
                chk("hs_expected", 64'(m_q.size() > 0), 1);
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    chk("hs_idx", 64'(p_idx), 64'(e.idx));
                    chk("hs_kind", 64'(p_kind), 64'(e.kind));
                    chk("hs_last", 64'(p_last), 64'(e.last));
                    m_rep_age = 0;
                end
                o.idx = int'(p_idx); o.kind = int'(p_kind); o.last = p_last;
                hs_log.push_back(o);
            end
        end else if (!p_en) begin
            m_armed = 0; m_run = 0;
        end else if (is_stop(p_i, p_c, p_a)) begin
            if (m_run < (1 << CW) - 1) m_run++;
            if (m_run == TH) begin
                m_dead = 1;
                m_dead_age = -1;
                m_time = m_cyc;
                build_report(p_c, p_a);
            end
        end else begin
            m_run = 0;
        end
        m_cyc = p_rst ? 32'd0 : m_cyc + 32'd1;
        if (m_dead) m_dead_age++;
        if (m_dead && m_q.size() > 0) m_rep_age++; else m_rep_age = 0;

        chk("deadlock", 64'(deadlock), 64'(m_dead));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_run));
        chk("busy", 64'(busy), 64'((!m_dead && m_run > 0) || (m_dead && m_q.size() > 0)));
`ifdef DF_WD_TIMESTAMP_EN
        chk("rpt_time", 64'(rpt_if.rpt_time), 64'(m_time));
`else
        chk("rpt_time", 64'(rpt_if.rpt_time), 0);
`endif
        if (!m_dead || m_q.size() == 0) chk("rpt_valid_idle", 64'(rpt_if.rpt_valid), 0);
        if (m_dead && m_dead_age == 0) chk("rpt_valid_latency", 64'(rpt_if.rpt_valid), 0);
        if (m_dead) chk("rpt_progress_bound", 64'(m_rep_age < 200), 1);
        if (!p_rst && !eff_clr && p_val && !p_rdy) begin
            chk("hold_valid", 64'(rpt_if.rpt_valid), 1);
            chk("hold_idx", 64'(rpt_if.rpt_idx), 64'(p_idx));
            chk("hold_kind", 64'(rpt_if.rpt_kind), 64'(p_kind));
            chk("hold_last", 64'(rpt_if.rpt_last), 64'(p_last));
        end
        if (p_rst) begin
            chk("rst_idx", 64'(rpt_if.rpt_idx), 0);
            chk("rst_kind", 64'(rpt_if.rpt_kind), 0);
            chk("rst_last", 64'(rpt_if.rpt_last), 0);
        end
    endtask

    task automatic set_case_a();
        axis_v = '0; chan_v = '0;
        axis_v[0] = 1'b1;
        chan_v[5] = 1'b1;
        chan_v[9] = 1'b1;
        idle_v = ~(axis_v | chan_v);
    endtask

    task automatic set_stop_rand();
        int v;
        int p;
        for (int k = 0; k < NP; k++) begin
            v = $urandom_range(1, 7);
            idle_v[k] = v[0]; chan_v[k] = v[1]; axis_v[k] = v[2];
        end
        p = $urandom_range(0, NP - 1);
        axis_v[p] = 1'b1;
    endtask

    task automatic set_nostop_rand();
        int p;
        idle_v = NP'($urandom); chan_v = NP'($urandom); axis_v = NP'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            p = $urandom_range(0, NP - 1);
            idle_v[p] = 1'b0; chan_v[p] = 1'b0; axis_v[p] = 1'b0;
        end else begin
            axis_v = '0;
        end
    endtask

    task automatic rand_ctrl();
        rpt_if.rpt_ready = 1'($urandom_range(0, 1));
        enable = ($urandom_range(0, 39) != 0);
        clear  = ($urandom_range(0, 79) == 0) ||
                 (m_dead && m_q.size() == 0 && $urandom_range(0, 7) == 0);
    endtask

    initial begin
        int k;
        reset = 1; enable = 0; clear = 0;
        idle_v = '0; chan_v = '0; axis_v = '0;
        rpt_if.rpt_ready = 0;
        step(); step();

        reset = 0; enable = 1; idle_v = '1;
        repeat (3) step();

        // Stop held three cycles only.
        idle_v = '1; idle_v[0] = 1'b0; axis_v = '0; axis_v[0] = 1'b1;
        repeat (3) step();
        chk("short_cnt3", 64'(stall_cnt), 3);
        axis_v = '0; idle_v = '1;
        step(); step();
        chk("short_cnt0", 64'(stall_cnt), 0);
        chk("short_no_dl", 64'(deadlock), 0);

        // Confirmed deadlock with back-pressure on the first entry.
        hs_log.delete();
        set_case_a();
        rpt_if.rpt_ready = 0;
        repeat (4) step();
        chk("dl_after_thresh", 64'(deadlock), 1);
        set_nostop_rand();
        k = 0;
        while (k < 20 && !rpt_if.rpt_valid) begin step(); k++; end
        chk("first_valid_seen", 64'(rpt_if.rpt_valid), 1);
        repeat (5) step();
        rpt_if.rpt_ready = 1;
        k = 0;
        while (k < 60 && m_q.size() > 0) begin set_nostop_rand(); step(); k++; end
        chk("report_drained", 64'(m_q.size()), 0);
        chk("log_len", 64'(hs_log.size()), 3);
        if (hs_log.size() == 3) begin
            chk("e0_idx", 64'(hs_log[0].idx), 0);
            chk("e0_kind", 64'(hs_log[0].kind), 2);
            chk("e0_last", 64'(hs_log[0].last), 0);
            chk("e1_idx", 64'(hs_log[1].idx), 5);
            chk("e1_kind", 64'(hs_log[1].kind), 1);
            chk("e1_last", 64'(hs_log[1].last), 0);
            chk("e2_idx", 64'(hs_log[2].idx), 9);
            chk("e2_kind", 64'(hs_log[2].kind), 1);
            chk("e2_last", 64'(hs_log[2].last), 1);
        end
        enable = 0;
        repeat (3) step();
        chk("done_hold_dl", 64'(deadlock), 1);
        chk("done_cnt", 64'(stall_cnt), TH);
        clear = 1; step(); clear = 0; enable = 1;
        chk("clear_dl", 64'(deadlock), 0);

        // Channel-only stall is not a deadlock.
        idle_v = '0; chan_v = '1; axis_v = '0;
        repeat (100) step();
        chk("chan_only_dl", 64'(deadlock), 0);
        chk("chan_only_cnt", 64'(stall_cnt), 0);

        // Clear while the second entry is on offer.
        hs_log.delete();
        set_case_a();
        rpt_if.rpt_ready = 1;
        repeat (4) step();
        k = 0;
        while (k < 60 && !(rpt_if.rpt_valid && hs_log.size() == 1)) begin step(); k++; end
        chk("entry2_offered", 64'(rpt_if.rpt_valid && hs_log.size() == 1), 1);
        clear = 1; step(); clear = 0;
        chk("clr_rpt_dl", 64'(deadlock), 0);
        chk("clr_rpt_valid", 64'(rpt_if.rpt_valid), 0);
        chk("clr_rpt_busy", 64'(busy), 0);

        // Reset while confirming.
        set_case_a();
        step(); step();
        chk("confirm_cnt2", 64'(stall_cnt), 2);
        reset = 1; step(); reset = 0;
        chk("rst_dl", 64'(deadlock), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cnt", 64'(stall_cnt), 0);
        chk("rst_valid", 64'(rpt_if.rpt_valid), 0);

        // Random episodes of stop / non-stop activity.
        for (int ep = 0; ep < 400; ep++) begin
            int len = $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                if (!m_dead) set_stop_rand(); else set_nostop_rand();
                rand_ctrl();
                step();
                clear = 0;
            end
            len = $urandom_range(1, 3);
            for (int c = 0; c < len; c++) begin
                set_nostop_rand();
                rand_ctrl();
                step();
                clear = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/df_deadlock_watchdog.md
Name: df_deadlock_watchdog

Overview:
- Dataflow deadlock watchdog controller for the myproject accelerator simulation and debug harness.
- Watches per-process idle, channel-block and axis-block status vectors and confirms a deadlock only when the stalled condition persists.
- On confirmation it latches a snapshot of the vectors and serially reports each stalled process over a valid/ready stream.
- Sits beside the dataflow region, between the instance status taps and the testbench or debug logger.

Parameters:
- NUM_PROC, 14, number of dataflow processes monitored.
- THRESH, 16, consecutive stalled cycles required to declare deadlock (must be at least 2).
- CNT_W, 16, width of persistence counter and stall_cnt output.

Ports:
- clock  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- enable  in  1  watchdog armed.
- clear  in  1  one-cycle pulse: drop deadlock, abort report, return to WATCH.
- inst_idle_sigs  in  NUM_PROC  per-process idle.
- inst_block_sigs  in  NUM_PROC  per-process FIFO/channel blocked.
- axis_block_sigs  in  NUM_PROC  per-process AXI-stream blocked, already mapped to process index.
- deadlock  out  1  latched deadlock flag.
- busy  out  1  high in CONFIRM or REPORT.
- stall_cnt  out  CNT_W  current persistence count.
- rpt_valid  out  1  report entry valid.
- rpt_ready  in  1  consumer accepts entry.
- rpt_idx  out  $clog2(NUM_PROC)  process index of entry.
- rpt_kind  out  2  bit0 = channel block, bit1 = axis block.
- rpt_last  out  1  final entry of the report.
- rpt_time  out  32  cycle stamp of confirmation (see optional feature).

Behaviour:
- Stop condition, stop:
  - every process has idle, chan_block or axis_block set; and
  - at least one axis_block bit is set.
- Reset: state IDLE; deadlock=0, busy=0, stall_cnt=0, rpt_valid=0, rpt_idx=0, rpt_kind=0, rpt_last=0, rpt_time=0.
- States and transitions:
  - IDLE: go to WATCH when enable=1.
  - WATCH:
    - enable=0 goes to IDLE.
    - stop=1 goes to CONFIRM with stall_cnt=1.
  - CONFIRM:
    - stop=1 increments stall_cnt.
    - When stall_cnt==THRESH-1 and stop=1: set deadlock=1 next cycle, snapshot all three vectors into a stalled mask (processes with chan or axis bit set), go to REPORT.
    - stop=0 clears stall_cnt and goes to WATCH.
    - enable=0 goes to IDLE with stall_cnt=0.
    - Deadlock is declared on the THRESH-th consecutive stop cycle.
  - REPORT:
    - Scan pointer walks from index 0 upward over the snapshot, not the live vectors.
    - Non-stalled indices are skipped one per cycle with rpt_valid=0.
    - For a stalled index: rpt_valid=1; rpt_idx, rpt_kind and rpt_last are held stable until rpt_ready=1.
    - rpt_last=1 when no higher stalled bit remains in the mask.
    - Transfer with rpt_last=1 goes to DONE.
    - The mask is never empty, because an axis bit is guaranteed.
  - DONE: deadlock held at 1, rpt_valid=0, stall_cnt frozen.
- enable has no effect in REPORT or DONE; only clear or reset leaves them.
- clear, in any state except IDLE: next state WATCH, with deadlock=0, stall_cnt=0, rpt_valid=0. clear beats a same-cycle confirmation or handshake.
- Reset mid-report: outputs return to reset values next cycle; the partial report is discarded.
- stall_cnt saturates at 2^CNT_W-1 and never wraps.
- Latency from the THRESH-th stop cycle:
  - deadlock high 1 cycle later.
  - First rpt_valid no earlier than 2 cycles later.

Optional Feature:
- DF_WD_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter runs from reset; it wraps modulo 2^32.
  - Its value is captured into rpt_time at confirmation and held until clear or reset.
- Not defined: rpt_time is tied to 0 and the counter is not instantiated.

Decomposition:
- Package df_wd_pkg holds:
  - State enum (IDLE, WATCH, CONFIRM, REPORT, DONE).
  - Kind encodings: KIND_CHAN=2'b01, KIND_AXIS=2'b10, KIND_BOTH=2'b11.
  - Default THRESH constant.
- Sub-module df_wd_persist_cnt: saturating counter with clear, increment and hit-threshold outputs.

Test Plan:
- Unless noted, tests use NUM_PROC=14 and THRESH=4.
- Short stall: stop held 3 cycles then dropped -> deadlock stays 0, stall_cnt returns to 0, state WATCH.
- Confirmed deadlock: process 0 axis-blocked, processes 5 and 9 chan-blocked, others idle, held 4 cycles -> deadlock=1; report entries are (0, 2'b10, last=0), (5, 2'b01, 0), (9, 2'b01, 1); then DONE.
- Back-pressure: in the previous case hold rpt_ready=0 for 5 cycles on the first entry -> rpt_valid stays 1 and idx/kind stay stable; the entry completes once ready rises.
- All chan-blocked, no axis bit, for 100 cycles -> no deadlock, stall_cnt=0.
- clear in REPORT during entry 2 -> next cycle deadlock=0, rpt_valid=0, state WATCH. Reset asserted in CONFIRM -> all outputs return to reset values.
- With DF_WD_TIMESTAMP_EN: confirm at cycle 57 after reset -> rpt_time=57 until clear. Without the macro -> rpt_time=0.
